// File: rtl/noise_channel_pkg.sv
// Shared constants and helpers for the noise channel.
// Holds the divisor table, LFSR seed, length limit and the period helper.
// Imported by noise_channel and vol_envelope.
package noise_channel_pkg;

  localparam int               TIMER_W   = 22;  // 112 << 15 still fits
  localparam logic [14:0]      LFSR_SEED = 15'h7FFF;
  localparam int               LEN_MAX   = 64;

  localparam logic [6:0] NOISE_DIVISOR [8] = '{
    7'd8, 7'd16, 7'd32, 7'd48, 7'd64, 7'd80, 7'd96, 7'd112
  };

  // Frequency-timer reload value: D(r) << s.
  function automatic logic [TIMER_W-1:0] noise_period(input logic [2:0] r,
                                                      input logic [3:0] s);
    logic [TIMER_W-1:0] p;
    p = {{(TIMER_W-7){1'b0}}, NOISE_DIVISOR[r]};
    return p << s;
  endfunction

endpackage

// File: rtl/vol_envelope.sv
// Volume envelope: loads an initial volume and steps it +/-1 every
// env_period ticks, saturating at 0 and 15; env_period = 0 freezes it.
// Ports: clk/rst_n, load (restart), tick (one-cycle step pulse),
// init_vol, env_dir, env_period in; volume out (registered).
module vol_envelope
  import noise_channel_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic       tick,
  input  logic [3:0] init_vol,
  input  logic       env_dir,
  input  logic [2:0] env_period,
  output logic [3:0] volume
);

  logic [3:0] vol_q, vol_d;
  logic [2:0] cnt_q, cnt_d;

  always_comb begin
    vol_d = vol_q;
    cnt_d = cnt_q;
    if (load) begin
      vol_d = init_vol;
      cnt_d = env_period;
    end else if (tick && (env_period != 3'd0)) begin
      // A count of 1 (or 0 after reset) reaches zero on this tick.
      if (cnt_q <= 3'd1) begin
        cnt_d = env_period;
        if (env_dir && (vol_q != 4'hF))
          vol_d = vol_q + 4'd1;
        else if (!env_dir && (vol_q != 4'h0))
          vol_d = vol_q - 4'd1;
      end else begin
        cnt_d = cnt_q - 3'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vol_q <= 4'd0;
      cnt_q <= 3'd0;
    end else begin
      vol_q <= vol_d;
      cnt_q <= cnt_d;
    end
  end

  assign volume = vol_q;

endmodule

// File: rtl/noise_channel.sv
// Noise channel: LFSR stepped by a programmable divider, gated by a length
// counter and scaled by a volume envelope. Tick/trigger inputs are levels
// that are rising-edge detected in the clk domain; noise is registered.
module noise_channel
  import noise_channel_pkg::*;
#(
  parameter int LFSR_W = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clk256,
  input  logic       clk64,
  input  logic [5:0] length,
  input  logic [3:0] initVol,
  input  logic       envDir,
  input  logic [2:0] envPeriod,
  input  logic [3:0] clockShift,
  input  logic       widthMode,
  input  logic [2:0] divisorCode,
  input  logic       trigger,
  input  logic       lengthEnable,
  output logic [3:0] noise
);

  logic               trig_hist_q, trig_hist_d;
  logic               c256_hist_q, c256_hist_d;
  logic               c64_hist_q,  c64_hist_d;
  logic [LFSR_W-1:0]  lfsr_q, lfsr_d, lfsr_step;
  logic [TIMER_W-1:0] timer_q, timer_d, period;
  logic [6:0]         len_q, len_d;
  logic               en_q, en_d;
  logic [3:0]         noise_q, noise_d;
  logic [3:0]         volume;
  logic               trig_edge, tick256, tick64, dac_on, fb;

  // A trigger edge in the same cycle as a tick wins; the tick is dropped.
  assign trig_edge = trigger & ~trig_hist_q;
  assign tick256   = clk256 & ~c256_hist_q & ~trig_edge;
  assign tick64    = clk64  & ~c64_hist_q  & ~trig_edge;
  assign dac_on    = (initVol != 4'd0) | envDir;
  assign period    = noise_period(divisorCode, clockShift);

  always_comb begin
    fb        = lfsr_q[0] ^ lfsr_q[1];
    lfsr_step = {fb, lfsr_q[LFSR_W-1:1]};
    if (widthMode) lfsr_step[6] = fb;
  end

  always_comb begin
    trig_hist_d = trigger;
    c256_hist_d = clk256;
    c64_hist_d  = clk64;
    lfsr_d      = lfsr_q;
    timer_d     = timer_q;
    len_d       = len_q;
    en_d        = en_q;
    if (trig_edge) begin
      en_d    = 1'b1;
      lfsr_d  = LFSR_W'(LFSR_SEED);
      len_d   = 7'(LEN_MAX) - {1'b0, length};
      timer_d = period;
    end else begin
      // Reload samples the current divisor/shift, so changes apply only
      // from the next period on.
      if (timer_q <= TIMER_W'(1)) begin
        timer_d = period;
        if (clockShift < 4'd14) lfsr_d = lfsr_step;
      end else begin
        timer_d = timer_q - TIMER_W'(1);
      end
      if (tick256 && lengthEnable && (len_q != 7'd0)) begin
        len_d = len_q - 7'd1;
        if (len_q == 7'd1) en_d = 1'b0;
      end
    end
    if (!dac_on) en_d = 1'b0;
    noise_d = (en_q && !lfsr_q[0]) ? volume : 4'd0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      trig_hist_q <= 1'b0;
      c256_hist_q <= 1'b0;
      c64_hist_q  <= 1'b0;
      lfsr_q      <= LFSR_W'(LFSR_SEED);
      timer_q     <= '0;
      len_q       <= 7'd0;
      en_q        <= 1'b0;
      noise_q     <= 4'd0;
    end else begin
      trig_hist_q <= trig_hist_d;
      c256_hist_q <= c256_hist_d;
      c64_hist_q  <= c64_hist_d;
      lfsr_q      <= lfsr_d;
      timer_q     <= timer_d;
      len_q       <= len_d;
      en_q        <= en_d;
      noise_q     <= noise_d;
    end
  end

  vol_envelope u_env (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (trig_edge),
    .tick       (tick64),
    .init_vol   (initVol),
    .env_dir    (envDir),
    .env_period (envPeriod),
    .volume     (volume)
  );

  assign noise = noise_q;

endmodule

// File: tb/tb_noise_channel.sv
module tb_noise_channel;

  logic       clk = 1'b0, rst_n = 1'b0;
  logic       clk256 = 1'b0, clk64 = 1'b0;
  logic [5:0] length = '0;
  logic [3:0] initVol = '0, clockShift = '0;
  logic       envDir = 1'b0, widthMode = 1'b0, trigger = 1'b0, lengthEnable = 1'b0;
  logic [2:0] envPeriod = '0, divisorCode = '0;
  logic [3:0] noise;

  int checks = 0;
  int failures = 0;
  int div_tab [8] = '{8, 16, 32, 48, 64, 80, 96, 112};

  noise_channel #(.LFSR_W(15)) dut (
    .clk(clk), .rst_n(rst_n), .clk256(clk256), .clk64(clk64),
    .length(length), .initVol(initVol), .envDir(envDir), .envPeriod(envPeriod),
    .clockShift(clockShift), .widthMode(widthMode), .divisorCode(divisorCode),
    .trigger(trigger), .lengthEnable(lengthEnable), .noise(noise)
  );

  always #125 clk = ~clk;

  function automatic logic [14:0] lfsr_next(input logic [14:0] m, input bit wm);
    logic x;
    logic [14:0] r;
    x = m[0] ^ m[1];
    r = {x, m[14:1]};
    if (wm) r[6] = x;
    return r;
  endfunction

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic trig_pulse();
    @(negedge clk); trigger = 1'b1;
    @(negedge clk); trigger = 1'b0;
  endtask

  task automatic pulse64();
    @(negedge clk); clk64 = 1'b1; cycles(2); clk64 = 1'b0; cycles(2);
  endtask

  task automatic pulse256();
    @(negedge clk); clk256 = 1'b1; cycles(2); clk256 = 1'b0; cycles(1);
  endtask

  task automatic peak(input int n, output int pk);
    pk = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (int'(noise) > pk) pk = int'(noise);
    end
  endtask

  task automatic setup(input logic [3:0] v, input bit d, input logic [2:0] ep,
                       input logic [2:0] r, input logic [3:0] s, input bit wm,
                       input logic [5:0] len, input bit le);
    initVol = v; envDir = d; envPeriod = ep; divisorCode = r;
    clockShift = s; widthMode = wm; length = len; lengthEnable = le;
  endtask

  // Trigger, then compare every cycle with the step-count model: the sample
  // taken after clock k shows the state after clock k-1, which has taken
  // floor((k-2)/per) LFSR steps.
  task automatic check_run(input int per, input bit wm, input logic [3:0] vol,
                           input int nsamp, input string nm);
    logic [14:0] m;
    logic [3:0]  exp;
    int steps;
    m = 15'h7FFF; steps = 0;
    @(negedge clk); trigger = 1'b1;
    for (int k = 1; k <= nsamp; k++) begin
      @(negedge clk); trigger = 1'b0;
      if (k >= 2) begin
        while (steps < (k - 2) / per) begin m = lfsr_next(m, wm); steps++; end
        exp = m[0] ? 4'd0 : vol;
        checks++;
        if (noise !== exp) begin
          failures++;
          $display("FAIL %s k=%0d noise=%0d expected=%0d", nm, k, noise, exp);
        end
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    cycles(3);
    checks++;
    if (noise !== 4'd0) begin failures++; $display("FAIL reset_hold noise=%0d expected=0", noise); end
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      checks++;
      if (noise !== 4'd0) begin failures++; $display("FAIL reset_idle noise=%0d expected=0", noise); end
    end
  endtask

  task automatic test_dac_off();
    int pk;
    setup(4'd0, 1'b0, 3'd1, 3'd0, 4'd0, 1'b0, 6'd0, 1'b0);
    trig_pulse();
    for (int i = 0; i < 168; i++) begin
      @(negedge clk);
      checks++;
      if (noise !== 4'd0) begin failures++; $display("FAIL dac_off noise=%0d expected=0", noise); end
    end
    // DAC comes on but the channel was never enabled: still silent.
    envDir = 1'b1;
    pulse64();
    peak(400, pk);
    checks++;
    if (pk !== 0) begin failures++; $display("FAIL dac_off_disabled peak=%0d expected=0", pk); end
    trig_pulse();
    pulse64();
    peak(400, pk);
    checks++;
    if (pk !== 1) begin failures++; $display("FAIL dac_on_by_dir peak=%0d expected=1", pk); end
  endtask

  task automatic test_lfsr15();
    setup(4'd15, 1'b0, 3'd0, 3'd0, 4'd0, 1'b0, 6'd0, 1'b0);
    check_run(8, 1'b0, 4'd15, 8 * 300 + 2, "lfsr15");
  endtask

  task automatic test_lfsr7();
    setup(4'd15, 1'b0, 3'd0, 3'd0, 4'd0, 1'b1, 6'd0, 1'b0);
    check_run(8, 1'b1, 4'd15, 8 * 300 + 2, "lfsr7");
  endtask

  task automatic test_random_div();
    logic [2:0] r;
    logic [3:0] s, v;
    bit wm;
    int per;
    for (int it = 0; it < 3; it++) begin
      r = 3'($urandom_range(0, 7));
      s = 4'($urandom_range(0, 1));
      v = 4'($urandom_range(1, 15));
      wm = 1'($urandom_range(0, 1));
      per = div_tab[r] << s;
      setup(v, 1'b0, 3'd0, r, s, wm, 6'd0, 1'b0);
      check_run(per, wm, v, per * 30 + 2, "random_div");
    end
  endtask

  task automatic test_frozen_shift();
    setup(4'd15, 1'b0, 3'd0, 3'd0, 4'd14, 1'b0, 6'd0, 1'b0);
    check_run(1 << 30, 1'b0, 4'd15, 300, "shift14");
  endtask

  // Divisor changes right after trigger: first step still at 8, then every 16.
  task automatic test_divisor_change();
    logic [14:0] m;
    logic [3:0]  exp;
    int steps, want;
    setup(4'd15, 1'b0, 3'd0, 3'd0, 4'd0, 1'b0, 6'd0, 1'b0);
    m = 15'h7FFF; steps = 0;
    @(negedge clk); trigger = 1'b1;
    for (int k = 1; k <= 400; k++) begin
      @(negedge clk); trigger = 1'b0; divisorCode = 3'd1;
      if (k >= 2) begin
        want = (k - 1 < 9) ? 0 : 1 + (k - 1 - 9) / 16;
        while (steps < want) begin m = lfsr_next(m, 1'b0); steps++; end
        exp = m[0] ? 4'd0 : 4'd15;
        checks++;
        if (noise !== exp) begin
          failures++;
          $display("FAIL div_change k=%0d noise=%0d expected=%0d", k, noise, exp);
        end
      end
    end
  endtask

  task automatic test_length();
    int pk;
    setup(4'd8, 1'b0, 3'd0, 3'd0, 4'd0, 1'b0, 6'd63, 1'b1);
    trig_pulse();
    peak(400, pk);
    checks++;
    if (pk !== 8) begin failures++; $display("FAIL len63_before peak=%0d expected=8", pk); end
    pulse256();
    cycles(3);
    peak(400, pk);
    checks++;
    if (pk !== 0) begin failures++; $display("FAIL len63_after peak=%0d expected=0", pk); end
    // lengthEnable=0: ticks ignored.
    setup(4'd8, 1'b0, 3'd0, 3'd0, 4'd0, 1'b0, 6'd63, 1'b0);
    trig_pulse();
    pulse256();
    peak(400, pk);
    checks++;
    if (pk !== 8) begin failures++; $display("FAIL len_disabled peak=%0d expected=8", pk); end
    // length=0 loads 64.
    setup(4'd8, 1'b0, 3'd0, 3'd0, 4'd0, 1'b0, 6'd0, 1'b1);
    trig_pulse();
    for (int i = 0; i < 63; i++) pulse256();
    peak(400, pk);
    checks++;
    if (pk !== 8) begin failures++; $display("FAIL len0_63 peak=%0d expected=8", pk); end
    pulse256();
    cycles(3);
    peak(400, pk);
    checks++;
    if (pk !== 0) begin failures++; $display("FAIL len0_64 peak=%0d expected=0", pk); end
  endtask

  task automatic test_envelope();
    int pk, want, v, p, k;
    bit d;
    int dn [4] = '{2, 1, 0, 0};
    int up [3] = '{14, 15, 15};
    setup(4'd2, 1'b0, 3'd1, 3'd0, 4'd0, 1'b0, 6'd0, 1'b0);
    trig_pulse();
    for (int i = 0; i < 4; i++) begin
      if (i > 0) pulse64();
      peak(400, pk);
      checks++;
      if (pk !== dn[i]) begin failures++; $display("FAIL env_down i=%0d peak=%0d expected=%0d", i, pk, dn[i]); end
    end
    setup(4'd14, 1'b1, 3'd1, 3'd0, 4'd0, 1'b0, 6'd0, 1'b0);
    trig_pulse();
    for (int i = 0; i < 3; i++) begin
      if (i > 0) pulse64();
      peak(400, pk);
      checks++;
      if (pk !== up[i]) begin failures++; $display("FAIL env_up i=%0d peak=%0d expected=%0d", i, pk, up[i]); end
    end
    for (int it = 0; it < 4; it++) begin
      v = $urandom_range(1, 15);
      d = 1'($urandom_range(0, 1));
      p = $urandom_range(1, 3);
      k = $urandom_range(0, 6);
      setup(4'(v), d, 3'(p), 3'd0, 4'd0, 1'b0, 6'd0, 1'b0);
      trig_pulse();
      for (int i = 0; i < k; i++) pulse64();
      want = d ? v + k / p : v - k / p;
      if (want > 15) want = 15;
      if (want < 0) want = 0;
      peak(400, pk);
      checks++;
      if (pk !== want) begin
        failures++;
        $display("FAIL env_rand v=%0d d=%0d p=%0d k=%0d peak=%0d expected=%0d", v, d, p, k, pk, want);
      end
    end
  endtask

  task automatic test_simultaneous();
    int pk;
    setup(4'd5, 1'b0, 3'd1, 3'd0, 4'd0, 1'b0, 6'd0, 1'b0);
    trig_pulse();
    pulse64();
    peak(400, pk);
    checks++;
    if (pk !== 4) begin failures++; $display("FAIL simul_pre peak=%0d expected=4", pk); end
    @(negedge clk); trigger = 1'b1; clk64 = 1'b1;
    @(negedge clk); trigger = 1'b0; clk64 = 1'b0;
    peak(400, pk);
    checks++;
    if (pk !== 5) begin failures++; $display("FAIL simul_trig_wins peak=%0d expected=5", pk); end
  endtask

  task automatic test_retrigger();
    int pk;
    setup(4'd9, 1'b0, 3'd1, 3'd0, 4'd0, 1'b0, 6'd0, 1'b0);
    trig_pulse();
    pulse64(); pulse64(); pulse64();
    peak(400, pk);
    checks++;
    if (pk !== 6) begin failures++; $display("FAIL retrig_decayed peak=%0d expected=6", pk); end
    trig_pulse();
    peak(400, pk);
    checks++;
    if (pk !== 9) begin failures++; $display("FAIL retrig_volume peak=%0d expected=9", pk); end
    setup(4'd11, 1'b0, 3'd0, 3'd0, 4'd0, 1'b0, 6'd0, 1'b0);
    check_run(8, 1'b0, 4'd11, 8 * 25 + 2, "retrig_run1");
    check_run(8, 1'b0, 4'd11, 8 * 25 + 2, "retrig_run2");
  endtask

  task automatic test_async_reset();
    bit seen;
    setup(4'd15, 1'b0, 3'd0, 3'd0, 4'd0, 1'b0, 6'd0, 1'b0);
    trig_pulse();
    seen = 1'b0;
    for (int n = 0; n < 1000 && !seen; n++) begin
      @(negedge clk);
      if (noise != 4'd0) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b1) begin failures++; $display("FAIL areset_precond seen=%0d expected=1", seen); end
    #20 rst_n = 1'b0;
    #1;
    checks++;
    if (noise !== 4'd0) begin failures++; $display("FAIL areset_immediate noise=%0d expected=0", noise); end
    cycles(2);
    rst_n = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      checks++;
      if (noise !== 4'd0) begin failures++; $display("FAIL areset_disabled noise=%0d expected=0", noise); end
    end
    check_run(8, 1'b0, 4'd15, 8 * 20 + 2, "after_reset");
  endtask

  initial begin
    test_reset();
    test_dac_off();
    test_lfsr15();
    test_lfsr7();
    test_random_div();
    test_frozen_shift();
    test_divisor_change();
    test_length();
    test_envelope();
    test_simultaneous();
    test_retrigger();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
